// File: rtl/cpu_pkg.sv
// Shared cpu core constants: default widths, reset vector, PC stride and NOP encoding.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int DEF_PC_INC = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decode valid/ready channel.
interface fetch_stage_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = INSTR_W
);

    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd;
    logic [DATA_W-1:0] imem_q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_addr,
        output imem_rd,
        input  imem_q,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        input  imem_rd,
        output imem_q,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Synchronous FIFO with synchronous flush and occupancy count; DEPTH must be a power of two.
module fifo_sync #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!nreset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage is data only; the pointers above decide what is live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues single-cycle RAM reads and queues
// returned {pc, instr} pairs for decode, with redirect-and-flush for branches.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = INSTR_W,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(DEF_PC_INC)
) (
    input  logic              clk,
    input  logic              nreset,
    fetch_stage_if.master     bus,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [7:0]        debug_pc
);

    localparam int CNT_W   = $clog2(QDEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_pc_p1;
    logic               inflight_p1;
    logic               kill_p1;
    logic               issue;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     occupancy;
    logic [ENTRY_W-1:0] head;

    // Stage p0: issue. Outstanding read counts against queue space so a push never overflows.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_p1};
    assign issue     = nreset && !redirect_valid && (occupancy < (CNT_W + 1)'(QDEPTH));

    always_ff @(posedge clk) begin
        if (!nreset) begin
            pc          <= RESET_PC;
            inflight_p1 <= 1'b0;
            kill_p1     <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            inflight_p1 <= 1'b0;
            kill_p1     <= inflight_p1;
        end else begin
            kill_p1     <= 1'b0;
            inflight_p1 <= issue;
            if (issue) pc <= pc + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) req_pc_p1 <= pc;
    end

    // Stage p1: capture the RAM word alongside the PC that requested it.
    assign push = inflight_p1 && !kill_p1;
    assign pop  = bus.out_valid && bus.out_ready;

    fifo_sync #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk    (clk),
        .nreset (nreset),
        .flush  (redirect_valid),
        .push   (push),
        .pop    (pop),
        .din    ({req_pc_p1, bus.imem_q}),
        .dout   (head),
        .count  (count)
    );

    // Stage p2: queue head to decode; everything forced quiet while held in reset.
    assign bus.imem_rd   = issue;
    assign bus.imem_addr = nreset ? pc : RESET_PC;
    assign debug_pc      = bus.imem_addr[7:0];
    assign bus.out_valid = nreset && (count != '0);
    assign bus.out_pc    = nreset ? head[ENTRY_W-1:DATA_W] : '0;
    assign bus.out_instr = nreset ? head[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table on a RESET_PC=0 instance,
// plus a hand-written wrap-around sequence on a RESET_PC=0xFFFF_FFF8 instance.
module tb_fetch_stage;

    localparam logic [31:0] PAT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        nreset0;
    logic        rv0;
    logic [31:0] rpc0;
    logic [7:0]  dbg0;
    logic        nreset1;
    logic        rv1;
    logic [31:0] rpc1;
    logic [7:0]  dbg1;

    int checks = 0;
    int fails  = 0;

    fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    fetch_stage #(
        .ADDR_W(32), .DATA_W(32), .QDEPTH(4), .RESET_PC(32'h0000_0000), .PC_INC(32'd4)
    ) dut0 (
        .clk(clk), .nreset(nreset0), .bus(bus0),
        .redirect_valid(rv0), .redirect_pc(rpc0), .debug_pc(dbg0)
    );

    fetch_stage #(
        .ADDR_W(32), .DATA_W(32), .QDEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_INC(32'd4)
    ) dut1 (
        .clk(clk), .nreset(nreset1), .bus(bus1),
        .redirect_valid(rv1), .redirect_pc(rpc1), .debug_pc(dbg1)
    );

    // Single-cycle-read instruction RAM: word = addr ^ PAT, valid the cycle after the read.
    always @(posedge clk) begin
        if (bus0.imem_rd) bus0.imem_q <= bus0.imem_addr ^ PAT;
        if (bus1.imem_rd) bus1.imem_q <= bus1.imem_addr ^ PAT;
    end

    typedef struct {
        logic        nrst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int nrst, input int rv, input int rpc, input int rdy,
                                input int erd, input int eaddr, input int evld, input int epc);
        vec_t v;
        v.nrst   = (nrst != 0);
        v.rv     = (rv != 0);
        v.rpc    = 32'(rpc);
        v.rdy    = (rdy != 0);
        v.e_rd   = (erd != 0);
        v.e_addr = 32'(eaddr);
        v.e_vld  = (evld != 0);
        v.e_pc   = 32'(epc);
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row=%0d actual=%h required=%h", nm, row, act, exp);
        end
    endtask

    initial begin
        int          first;
        logic [31:0] exp_pc1 [4];
        logic [31:0] e_instr;

        nreset0 = 1'b0; rv0 = 1'b0; rpc0 = '0; bus0.out_ready = 1'b0;
        nreset1 = 1'b0; rv1 = 1'b0; rpc1 = '0; bus1.out_ready = 1'b1;

        // Streaming with out_ready high, then redirect to 0x200 coincident with the pc 0x8 handshake.
        tbl.push_back(mk(0,0,0,1,     0,'h0,0,0));
        tbl.push_back(mk(0,0,0,1,     0,'h0,0,0));
        tbl.push_back(mk(1,0,0,1,     1,'h0,0,0));
        tbl.push_back(mk(1,0,0,1,     1,'h4,0,0));
        tbl.push_back(mk(1,0,0,1,     1,'h8,1,'h0));
        tbl.push_back(mk(1,0,0,1,     1,'hC,1,'h4));
        tbl.push_back(mk(1,1,'h200,1, 0,'h10,1,'h8));
        tbl.push_back(mk(1,0,0,1,     1,'h200,0,0));
        tbl.push_back(mk(1,0,0,1,     1,'h204,0,0));
        tbl.push_back(mk(1,0,0,1,     1,'h208,1,'h200));
        tbl.push_back(mk(1,0,0,1,     1,'h20C,1,'h204));
        // Reset mid-stream, then backpressure from reset: four reads, stall, drain in order.
        tbl.push_back(mk(0,0,0,0,     0,'h0,0,0));
        tbl.push_back(mk(1,0,0,0,     1,'h0,0,0));
        tbl.push_back(mk(1,0,0,0,     1,'h4,0,0));
        tbl.push_back(mk(1,0,0,0,     1,'h8,1,'h0));
        tbl.push_back(mk(1,0,0,0,     1,'hC,1,'h0));
        tbl.push_back(mk(1,0,0,0,     0,'h10,1,'h0));
        tbl.push_back(mk(1,0,0,0,     0,'h10,1,'h0));
        tbl.push_back(mk(1,0,0,0,     0,'h10,1,'h0));
        tbl.push_back(mk(1,0,0,1,     0,'h10,1,'h0));
        tbl.push_back(mk(1,0,0,1,     1,'h10,1,'h4));
        tbl.push_back(mk(1,0,0,1,     1,'h14,1,'h8));
        tbl.push_back(mk(1,0,0,1,     1,'h18,1,'hC));
        tbl.push_back(mk(1,0,0,1,     1,'h1C,1,'h10));
        tbl.push_back(mk(1,0,0,1,     1,'h20,1,'h14));
        // Refill to full with out_ready low, then a one-cycle reset and restart from RESET_PC.
        tbl.push_back(mk(1,0,0,0,     1,'h24,1,'h18));
        tbl.push_back(mk(1,0,0,0,     0,'h28,1,'h18));
        tbl.push_back(mk(1,0,0,0,     0,'h28,1,'h18));
        tbl.push_back(mk(0,0,0,0,     0,'h0,0,0));
        tbl.push_back(mk(1,0,0,0,     1,'h0,0,0));
        tbl.push_back(mk(1,0,0,0,     1,'h4,0,0));
        tbl.push_back(mk(1,0,0,0,     1,'h8,1,'h0));
        tbl.push_back(mk(1,0,0,1,     1,'hC,1,'h0));
        tbl.push_back(mk(1,0,0,1,     1,'h10,1,'h4));
        // Redirect ignored in reset; then redirect to 0x100 with 2 queued and one read in flight.
        tbl.push_back(mk(0,1,'h300,0, 0,'h0,0,0));
        tbl.push_back(mk(1,0,0,0,     1,'h0,0,0));
        tbl.push_back(mk(1,0,0,0,     1,'h4,0,0));
        tbl.push_back(mk(1,0,0,0,     1,'h8,1,'h0));
        tbl.push_back(mk(1,1,'h100,0, 0,'hC,1,'h0));
        tbl.push_back(mk(1,0,0,1,     1,'h100,0,0));
        tbl.push_back(mk(1,0,0,1,     1,'h104,0,0));
        tbl.push_back(mk(1,0,0,1,     1,'h108,1,'h100));
        tbl.push_back(mk(1,0,0,1,     1,'h10C,1,'h104));
        tbl.push_back(mk(1,0,0,1,     1,'h110,1,'h108));

        for (int i = 0; i < tbl.size(); i++) begin
            nreset0        = tbl[i].nrst;
            rv0            = tbl[i].rv;
            rpc0           = tbl[i].rpc;
            bus0.out_ready = tbl[i].rdy;
            @(negedge clk);
            chk("imem_rd",   i, 32'(bus0.imem_rd),   32'(tbl[i].e_rd));
            chk("imem_addr", i, bus0.imem_addr,      tbl[i].e_addr);
            chk("debug_pc",  i, 32'(dbg0),           32'(tbl[i].e_addr[7:0]));
            chk("out_valid", i, 32'(bus0.out_valid), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld || !tbl[i].nrst) begin
                e_instr = tbl[i].nrst ? (tbl[i].e_pc ^ PAT) : 32'h0;
                chk("out_pc",    i, bus0.out_pc,    tbl[i].e_pc);
                chk("out_instr", i, bus0.out_instr, e_instr);
            end
            @(posedge clk);
            #1;
        end

        // Wrap-around instance, still in reset here.
        @(negedge clk);
        chk("w_rst_addr",  100, bus1.imem_addr,      32'hFFFF_FFF8);
        chk("w_rst_dbg",   100, 32'(dbg1),           32'h0000_00F8);
        chk("w_rst_valid", 100, 32'(bus1.out_valid), 32'h0);
        chk("w_rst_rd",    100, 32'(bus1.imem_rd),   32'h0);
        @(posedge clk);
        #1;
        nreset1 = 1'b1;

        exp_pc1[0] = 32'hFFFF_FFF8;
        exp_pc1[1] = 32'hFFFF_FFFC;
        exp_pc1[2] = 32'h0000_0000;
        exp_pc1[3] = 32'h0000_0004;

        first = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("w_c0_rd",   101, 32'(bus1.imem_rd), 32'h1);
                chk("w_c0_addr", 101, bus1.imem_addr,    32'hFFFF_FFF8);
            end
            if (bus1.out_valid) begin
                first = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("w_first_valid_cycle", 102, 32'(first), 32'd2);

        if (first >= 0) begin
            for (int k = 0; k < 4; k++) begin
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                end
                chk("w_valid", 110 + k, 32'(bus1.out_valid), 32'h1);
                chk("w_pc",    110 + k, bus1.out_pc,         exp_pc1[k]);
                chk("w_instr", 110 + k, bus1.out_instr,      exp_pc1[k] ^ PAT);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
